fetch_ctrl: RTL and testbench

- Sequences the fetch stage of the 5-stage RISC-V pipeline against an instruction memory with a req/gnt/rvalid handshake and variable latency.
- Owns PCF and issues one fetch at a time.
- Applies execute-stage redirects (PCSrcE/PCTargetE) and discards stale responses.
- Honours hazard-unit stalls and drives the F/D pipeline register (InstrD, PCD, PCPlus4D, ValidD).

---
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns PCF, runs a one-outstanding req/gnt/rvalid
// fetch against instruction memory and drives the F/D pipeline register.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] pcf_plus4;
    logic [31:0] redirect_pc;

    // Low target bits are forced to zero, so they never reach any logic.
    logic unused_tgt;
    assign unused_tgt = ^PCTargetE[1:0];

    assign pcf_plus4   = pcf_q + 32'd4;
    assign redirect_pc = {PCTargetE[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pc4_d        = pc4_q;
        valid_d      = StallF ? valid_q : 1'b0;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!StallF) begin
                        instr_d = imem_rdata;
                        pcd_d   = pcf_q;
                        pc4_d   = pcf_plus4;
                        valid_d = 1'b1;
                        pcf_d   = pcf_plus4;
                        state_d = S_REQ;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pcf_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!StallF) begin
                    instr_d = hold_instr_q;
                    pcd_d   = hold_pc_q;
                    pc4_d   = hold_pc_q + 32'd4;
                    valid_d = 1'b1;
                    pcf_d   = pcf_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect wins over everything: flush D, retarget PCF, and make
        // sure any response already granted for the old path is swallowed.
        if (PCSrcE) begin
            pcf_d        = redirect_pc;
            valid_d      = 1'b0;
            instr_d      = instr_q;
            pcd_d        = pcd_q;
            pc4_d        = pc4_q;
            hold_instr_d = hold_instr_q;
            hold_pc_d    = hold_pc_q;
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ  : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rvalid ? S_REQ  : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pcf_q        <= RESET_PC;
            instr_q      <= 32'd0;
            pcd_q        <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pc4_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a transaction-level model (granted-address FIFO,
// expected fetch stream) checks two instances against a random memory.
module tb_fetch_ctrl;

    localparam logic [31:0] RST2 = 32'hFFFFFFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCSrcE, StallF, gnt, rvalid;
    logic [31:0] tgt, rdata;
    logic        req, vld;
    logic [31:0] addr, instr, pcd, pc4;

    logic        src2, stall2, rv2, req2, vld2, gnt2;
    logic [31:0] tgt2, rd2, addr2, instr2, pcd2, pc42;
    assign gnt2 = req2;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(tgt), .StallF(StallF),
        .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rvalid),
        .imem_rdata(rdata), .InstrD(instr), .PCD(pcd), .PCPlus4D(pc4), .ValidD(vld)
    );

    fetch_ctrl #(.RESET_PC(RST2)) dut_wrap (
        .clk(clk), .rst(rst), .PCSrcE(src2), .PCTargetE(tgt2), .StallF(stall2),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2), .imem_rvalid(rv2),
        .imem_rdata(rd2), .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pc42), .ValidD(vld2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    // Reference state: addresses granted on the live path, awaiting delivery.
    logic [31:0] q[$];
    logic [31:0] exp_fetch;
    logic [31:0] out_addr;
    bit          outst;
    int          lat_cnt, gcnt, gmin, gmax, lmin, lmax, deliveries;
    bit          pend2, chk2;
    logic [31:0] a2;
    int          idx2, didx2;

    task automatic tick();
        logic        p_rst, p_src, p_stall, p_req, p_gnt, p_rv, p_req2, p_gnt2, p_rv2;
        logic [31:0] p_tgt, p_addr, p_instr, p_pcd, p_pc4, p_addr2, e;
        logic        p_vld;
        p_rst = rst; p_src = PCSrcE; p_stall = StallF; p_tgt = tgt;
        p_req = req; p_gnt = gnt; p_rv = rvalid; p_addr = addr;
        p_instr = instr; p_pcd = pcd; p_pc4 = pc4; p_vld = vld;
        p_req2 = req2; p_gnt2 = gnt2; p_rv2 = rv2; p_addr2 = addr2;
        @(posedge clk);
        #1;
        if (p_rst) begin
            chk("rst_req", req, 0);
            chk("rst_addr", addr, 32'h0);
            chk("rst_vld", vld, 0);
            chk("rst_instr", instr, 0);
            chk("rst_pcd", pcd, 0);
            chk("rst_pc4", pc4, 0);
            q.delete();
            exp_fetch = 32'h0;
            outst = 0;
            gcnt = $urandom_range(gmax, gmin);
            pend2 = 0; idx2 = 0; didx2 = 0;
            if (chk2) begin
                chk("rst2_req", req2, 0);
                chk("rst2_addr", addr2, RST2);
                chk("rst2_vld", vld2, 0);
                chk("rst2_instr", instr2, 0);
                chk("rst2_pcd", pcd2, 0);
                chk("rst2_pc4", pc42, 0);
            end
        end else begin
            if (outst) chk("req_outst", p_req, 0);
            if (p_rv) outst = 0;
            if (p_req && p_gnt) begin
                outst = 1;
                out_addr = p_addr;
                lat_cnt = $urandom_range(lmax, lmin);
                gcnt = $urandom_range(gmax, gmin);
                if (!p_src) begin
                    chk("fetch_addr", p_addr, exp_fetch);
                    q.push_back(p_addr);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
            if (p_src) begin
                q.delete();
                exp_fetch = {p_tgt[31:2], 2'b00};
                chk("flush_vld", vld, 0);
                chk("flush_pcd", pcd, p_pcd);
            end else if (p_stall) begin
                chk("stall_vld", vld, p_vld);
                chk("stall_instr", instr, p_instr);
                chk("stall_pcd", pcd, p_pcd);
                chk("stall_pc4", pc4, p_pc4);
            end else if (vld) begin
                chk("deliv_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("deliv_pcd", pcd, e);
                    chk("deliv_instr", instr, memword(e));
                    chk("deliv_pc4", pc4, e + 32'd4);
                    deliveries++;
                end
            end
            chk("q_depth", q.size() <= 1, 1);
            if (p_rv2) pend2 = 0;
            if (p_req2 && p_gnt2) begin
                pend2 = 1;
                a2 = p_addr2;
                if (chk2) begin
                    chk("wrap_addr", p_addr2, RST2 + 32'(4 * idx2));
                    idx2++;
                end
            end
            if (chk2 && vld2) begin
                e = RST2 + 32'(4 * didx2);
                chk("wrap_pcd", pcd2, e);
                chk("wrap_pc4", pc42, e + 32'd4);
                chk("wrap_instr", instr2, memword(e));
                didx2++;
            end
        end
        @(negedge clk);
        rvalid = 1'b0;
        rdata = 32'h0;
        if (outst) begin
            if (lat_cnt <= 1) begin
                rvalid = 1'b1;
                rdata = memword(out_addr);
            end else begin
                lat_cnt--;
            end
        end
        gnt = 1'b0;
        if (req) begin
            if (gcnt == 0) gnt = 1'b1;
            else gcnt--;
        end
        rv2 = pend2;
        rd2 = memword(a2);
    endtask

    task automatic do_reset();
        rst = 1'b1; PCSrcE = 1'b0; StallF = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("idle_req", req, 0);
    endtask

    initial begin
        int n;
        int d;
        rst = 1'b1; PCSrcE = 1'b0; tgt = 32'h0; StallF = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        src2 = 1'b0; stall2 = 1'b0; tgt2 = 32'h0; rv2 = 1'b0; rd2 = 32'h0;
        gmin = 0; gmax = 0; lmin = 1; lmax = 1; chk2 = 0;
        outst = 0; pend2 = 0; a2 = 32'h0; out_addr = 32'h0; exp_fetch = 32'h0;
        lat_cnt = 0; gcnt = 0; deliveries = 0; idx2 = 0; didx2 = 0;
        @(negedge clk);

        // 1: free-run with single-cycle memory, one instruction per two cycles
        do_reset();
        deliveries = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t1_req", req, k % 2);
            if (k >= 2) chk("t1_vld", vld, k % 2);
        end
        chk("t1_count", deliveries, 5);

        // 2: stall arriving with the response parks it in HOLD
        n = 0;
        while (!outst && n < 20) begin tick(); n++; end
        chk("t2_wait", outst, 1);
        StallF = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_hold_req", req, 0);
        end
        StallF = 1'b0;
        d = deliveries;
        tick();
        chk("t2_release", vld, 1);
        chk("t2_deliv", deliveries, d + 1);

        // 3: redirect in WAIT, stale response arrives two cycles later
        lmin = 3; lmax = 3;
        n = 0;
        while (!outst && n < 20) begin tick(); n++; end
        chk("t3_wait", outst, 1);
        PCSrcE = 1'b1; tgt = 32'h00000103;
        tick();
        PCSrcE = 1'b0;
        chk("t3_flush", vld, 0);
        n = 0;
        while (!req && n < 20) begin tick(); n++; end
        chk("t3_addr", addr, 32'h00000100);

        // 4: redirect together with gnt, then again while dropping
        n = 0;
        while (!(req && gnt) && n < 20) begin tick(); n++; end
        chk("t4_sync", req && gnt, 1);
        PCSrcE = 1'b1; tgt = 32'h00000180;
        tick();
        chk("t4_drop_req", req, 0);
        tgt = 32'h00000200;
        tick();
        PCSrcE = 1'b0;
        n = 0;
        while (!req && n < 20) begin tick(); n++; end
        chk("t4_addr", addr, 32'h00000200);
        n = 0;
        while (!vld && n < 20) begin tick(); n++; end
        chk("t4_pcd", pcd, 32'h00000200);

        // 5: random latency, stalls and redirects
        gmin = 0; gmax = 3; lmin = 1; lmax = 4;
        d = deliveries;
        for (int k = 0; k < 1500; k++) begin
            StallF = ($urandom_range(99, 0) < 20);
            PCSrcE = ($urandom_range(99, 0) < 4);
            tgt = $urandom;
            tick();
        end
        PCSrcE = 1'b0; StallF = 1'b0;
        chk("t5_progress", (deliveries - d) >= 50, 1);

        // 6: PC wrap from the top of the address space, then reset mid-WAIT
        gmin = 0; gmax = 0; lmin = 1; lmax = 1;
        chk2 = 1;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        chk("t6_count", idx2 >= 4, 1);
        n = 0;
        while (!pend2 && n < 20) begin tick(); n++; end
        chk("t6_wait", pend2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_idle_req", req2, 0);
        tick();
        chk("t6_req_after", req2, 1);
        chk("t6_addr_after", addr2, RST2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
